fp16_dot_seq: RTL and testbench

Sequential dot-product controller that sits directly upstream of the combinational fp16 multiply-accumulate datapath. It accepts a job (vector length plus initial accumulator), streams operand pairs in through a valid/ready handshake, and drives the MAC as `mac_op1 * mac_op2 + mac_ops`. Each MAC result is registered back as the running accumulator, one pair per cycle. When the job finishes it presents the final fp16 sum on a valid/ready output port.

---
 rtl/fp16_dot_seq.sv | 112 +++++++++++
 tb/tb_fp16_dot_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_dot_seq.sv
// Job sequencer for a combinational fp16 multiply-accumulate datapath.
// Streams operand pairs into the MAC and registers each result back as the running accumulator.
module fp16_dot_seq #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      init,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_op1,
    input  logic [15:0]      in_op2,
    output logic [15:0]      mac_op1,
    output logic [15:0]      mac_op2,
    output logic [15:0]      mac_ops,
    input  logic [15:0]      mac_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [LEN_W-1:0] skip_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [15:0]      acc_q;
    logic [LEN_W-1:0] remaining_q;
    logic [LEN_W-1:0] skip_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             beat;
    logic             zero_pair;

    always_comb begin
        beat      = in_valid & in_ready_q;
        // The MAC forces a hidden 1, so a +/-0 operand must bypass it entirely.
        zero_pair = (in_op1[14:0] == 15'd0) | (in_op2[14:0] == 15'd0);
        mac_op1   = in_op1;
        mac_op2   = in_op2;
        mac_ops   = acc_q;
        out_data  = acc_q;
        skip_cnt  = skip_q;
        in_ready  = in_ready_q;
        out_valid = out_valid_q;
        busy      = busy_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
            skip_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q       <= init;
                        remaining_q <= len;
                        skip_q      <= '0;
                        busy_q      <= 1'b1;
                        if (len == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q    <= RUN;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (beat) begin
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (zero_pair) begin
                            if (skip_q != '1)
                                skip_q <= skip_q + LEN_W'(1);
                        end else begin
                            acc_q <= mac_result;
                        end
                        if (remaining_q == LEN_W'(1)) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_dot_seq.sv
// Self-checking bench for fp16_dot_seq: directed table, hand-written corner sequences,
// and randomized jobs against a job-level reference model driven through a MAC stub.
module tb_fp16_dot_seq;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [15:0]      init;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_op1;
    logic [15:0]      in_op2;
    logic [15:0]      mac_op1;
    logic [15:0]      mac_op2;
    logic [15:0]      mac_ops;
    logic [15:0]      mac_result;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [LEN_W-1:0] skip_cnt;
    logic             busy;

    logic             stub_hash;

    fp16_dot_seq #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .init       (init),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op1     (in_op1),
        .in_op2     (in_op2),
        .mac_op1    (mac_op1),
        .mac_op2    (mac_op2),
        .mac_ops    (mac_ops),
        .mac_result (mac_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .skip_cnt   (skip_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // MAC stub: integer +1 for directed chaining, or an operand hash that exposes wiring errors.
    always_comb begin
        if (stub_hash) mac_result = mac_ops * 16'd5 + mac_op1 + (mac_op2 << 1);
        else           mac_result = mac_ops + 16'd1;
    end

    function automatic logic [15:0] mac_model(input logic [15:0] a, input logic [15:0] o1,
                                              input logic [15:0] o2);
        if (stub_hash) return a * 16'd5 + o1 + (o2 << 1);
        return a + 16'd1;
    endfunction

    function automatic bit is_zero(input logic [15:0] x);
        return x[14:0] == 15'd0;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [15:0] op1_a [256];
    logic [15:0] op2_a [256];

    // Caller is at a negedge. Streams op1_a/op2_a; gap_pct is the chance of an idle input cycle.
    task automatic run_job(input logic [7:0] l, input logic [15:0] ini, input int gap_pct,
                           output logic [15:0] got_out, output logic [7:0] got_skip,
                           output int beats, output int lat);
        logic [15:0] exp_acc;
        int k;
        exp_acc = ini;
        k = 0;
        beats = 0;
        start = 1'b1;
        len   = l;
        init  = ini;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!out_valid && lat < 2000) begin
            if (in_ready) begin
                chk("mac_ops_track", 32'(mac_ops), 32'(exp_acc));
                if (k < int'(l) && int'($urandom_range(99)) >= gap_pct) begin
                    in_op1   = op1_a[k];
                    in_op2   = op2_a[k];
                    in_valid = 1'b1;
                    if (!(is_zero(op1_a[k]) || is_zero(op2_a[k])))
                        exp_acc = mac_model(exp_acc, op1_a[k], op2_a[k]);
                    k++;
                    beats++;
                end else begin
                    in_valid = 1'b0;
                    in_op1   = 16'($urandom);
                    in_op2   = 16'($urandom);
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) chk("job_timeout", 32'(out_valid), 32'd1);
        got_out  = out_data;
        got_skip = skip_cnt;
        chk("out_vs_track", 32'(out_data), 32'(exp_acc));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("handoff_busy", 32'(busy), 32'd0);
        chk("handoff_valid", 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  l;
        logic [15:0] ini;
        logic [31:0] zmask;
        logic [15:0] exp_out;
        logic [7:0]  exp_skip;
    } vec_t;

    vec_t vt [8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] got_out;
        logic [7:0]  got_skip;
        int          beats;
        int          lat;
        logic [15:0] ref_acc;
        logic [7:0]  ref_skip;
        logic [7:0]  rl;
        logic [15:0] rini;

        vt[0] = '{8'd3,   16'h3C00, 32'h0000_0000, 16'h3C03, 8'd0};
        vt[1] = '{8'd4,   16'h3C00, 32'h0000_0002, 16'h3C03, 8'd1};
        vt[2] = '{8'd0,   16'h1234, 32'h0000_0000, 16'h1234, 8'd0};
        vt[3] = '{8'd1,   16'h3C00, 32'h0000_0000, 16'h3C01, 8'd0};
        vt[4] = '{8'd5,   16'h0000, 32'h0000_001F, 16'h0000, 8'd5};
        vt[5] = '{8'd8,   16'hFFFF, 32'h0000_0000, 16'h0007, 8'd0};
        vt[6] = '{8'd255, 16'h0100, 32'h0000_0000, 16'h01FF, 8'd0};
        vt[7] = '{8'd6,   16'h7BFF, 32'h0000_0028, 16'h7C03, 8'd2};

        rst_n = 1'b0; start = 1'b0; len = '0; init = '0; in_valid = 1'b0;
        in_op1 = '0; in_op2 = '0; out_ready = 1'b0; stub_hash = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_mac_ops", 32'(mac_ops), 32'd0);
        chk("rst_skip", 32'(skip_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 256; j++) begin
                op1_a[j] = 16'h4000;
                op2_a[j] = 16'h4200;
                if (j < 32 && vt[i].zmask[j]) begin
                    if (j % 2 == 1) op2_a[j] = 16'h8000;
                    else            op1_a[j] = 16'h0000;
                end
            end
            run_job(vt[i].l, vt[i].ini, 0, got_out, got_skip, beats, lat);
            chk($sformatf("vec%0d_out", i), 32'(got_out), 32'(vt[i].exp_out));
            chk($sformatf("vec%0d_skip", i), 32'(got_skip), 32'(vt[i].exp_skip));
            chk($sformatf("vec%0d_beats", i), 32'(beats), 32'(vt[i].l));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].l) + 32'd1);
        end

        // Backpressure on both sides, plus a start pulse while DONE.
        start = 1'b1; len = 8'd2; init = 16'h3C00;
        @(negedge clk);
        start = 1'b0;
        chk("bp_in_ready", 32'(in_ready), 32'd1);
        in_op1 = 16'h4000; in_op2 = 16'h4200; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_gap_acc", 32'(mac_ops), 32'h3C01);
            chk("bp_gap_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_done_valid", 32'(out_valid), 32'd1);
        chk("bp_done_data", 32'(out_data), 32'h3C02);
        for (int i = 0; i < 5; i++) begin
            chk("bp_stall_valid", 32'(out_valid), 32'd1);
            chk("bp_stall_data", 32'(out_data), 32'h3C02);
            chk("bp_stall_busy", 32'(busy), 32'd1);
            start = (i == 2);
            len = 8'd0; init = 16'h1111;
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("bp_no_queued_start", 32'(busy), 32'd0);
        chk("bp_no_queued_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of a 5-pair job, with one skipped pair already taken.
        start = 1'b1; len = 8'd5; init = 16'h3C00;
        @(negedge clk);
        start = 1'b0;
        in_op1 = 16'h4000; in_op2 = 16'h4200; in_valid = 1'b1;
        @(negedge clk);
        in_op2 = 16'h8000;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_skip_before", 32'(skip_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_mac_ops", 32'(mac_ops), 32'd0);
        chk("mid_rst_skip", 32'(skip_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'd0);
        op1_a[0] = 16'h4000; op2_a[0] = 16'h4200;
        run_job(8'd1, 16'h3C00, 0, got_out, got_skip, beats, lat);
        chk("post_rst_out", 32'(got_out), 32'h3C01);
        chk("post_rst_skip", 32'(got_skip), 32'd0);

        // Randomized jobs with input gaps against a job-level reference.
        stub_hash = 1'b1;
        for (int t = 0; t < 16; t++) begin
            rl   = 8'($urandom_range(20));
            rini = 16'($urandom);
            for (int j = 0; j < int'(rl); j++) begin
                op1_a[j] = 16'($urandom);
                op2_a[j] = 16'($urandom);
                if ($urandom_range(4) == 0) op1_a[j][14:0] = '0;
                if ($urandom_range(4) == 0) op2_a[j][14:0] = '0;
            end
            ref_acc  = rini;
            ref_skip = '0;
            for (int j = 0; j < int'(rl); j++) begin
                if (is_zero(op1_a[j]) || is_zero(op2_a[j])) ref_skip++;
                else ref_acc = ref_acc * 16'd5 + op1_a[j] + (op2_a[j] << 1);
            end
            run_job(rl, rini, 30, got_out, got_skip, beats, lat);
            chk($sformatf("rnd%0d_out", t), 32'(got_out), 32'(ref_acc));
            chk($sformatf("rnd%0d_skip", t), 32'(got_skip), 32'(ref_skip));
            chk($sformatf("rnd%0d_beats", t), 32'(beats), 32'(rl));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
